// File: rtl/aes_key_expand_seq.sv
// Sequential AES key schedule: latches an Nk-word cipher key and produces one
// schedule word per clock, then holds the full round-key bus until the next start.
module aes_key_expand_seq #(
   parameter int Nk = 4,
   parameter int Nr = Nk + 6
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [0:32*Nk-1]        key,
   output logic                    busy,
   output logic                    done,
   output logic                    keys_valid,
   output logic [0:128*(Nr+1)-1]   round_keys
);
   localparam int         NW   = 4 * (Nr + 1);
   localparam logic [5:0] LAST = 6'(NW - 1);
   localparam logic [5:0] NK6  = 6'(Nk);
   localparam logic [2:0] JMAX = 3'(Nk - 1);

   if (!(Nk == 4 || Nk == 6 || Nk == 8) || Nr != Nk + 6) begin : g_bad_param
      $error("aes_key_expand_seq: Nk must be 4, 6 or 8 and Nr must equal Nk+6");
   end

   // Forward S-box, entry 0 in the top byte.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sub_byte(input logic [7:0] b);
      return SBOX[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

   state_t      state, state_nxt;
   logic [31:0] w [0:NW-1];
   logic [5:0]  i;
   logic [2:0]  j;
   logic [7:0]  rcon;
   logic [31:0] prev, sub_in, sub_out, temp;
   logic        accept;

   assign accept = start && (state != EXPAND);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = EXPAND;
         EXPAND:  if (i == LAST) state_nxt = READY;
         READY:   if (start) state_nxt = EXPAND;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state == EXPAND);
      keys_valid = (state == READY);
   end

   // Single S-box word path, shared by the RotWord/Rcon step and the AES-256 mid-key step.
   always_comb begin
      prev    = w[i - 6'd1];
      sub_in  = (j == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
      sub_out = {sub_byte(sub_in[31:24]), sub_byte(sub_in[23:16]),
                 sub_byte(sub_in[15:8]),  sub_byte(sub_in[7:0])};
      if (j == 3'd0)                  temp = sub_out ^ {rcon, 24'h0};
      else if (Nk == 8 && j == 3'd4)  temp = sub_out;
      else                            temp = prev;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int n = 0; n < NW; n++) w[n] <= '0;
         i    <= '0;
         j    <= '0;
         rcon <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            for (int n = 0; n < Nk; n++) w[n] <= key[32*n +: 32];
            i    <= NK6;
            j    <= '0;
            rcon <= 8'h01;
         end else if (state == EXPAND) begin
            w[i] <= w[i - NK6] ^ temp;
            i    <= i + 6'd1;
            j    <= (j == JMAX) ? 3'd0 : j + 3'd1;
            if (j == 3'd0) rcon <= xtime(rcon);
            if (i == LAST) done <= 1'b1;
         end
      end
   end

   for (genvar n = 0; n < NW; n++) begin : g_rk
      assign round_keys[32*n +: 32] = w[n];
   end
endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed bench for aes_key_expand_seq: FIPS-197 vectors for AES-128/192/256,
// latency, ignored mid-expansion start, async reset and restart from READY.
module tb_aes_key_expand_seq;
   logic clk, reset;
   logic start4, start6, start8;
   logic [0:127] key4;
   logic [0:191] key6;
   logic [0:255] key8;
   logic busy4, done4, kv4, busy6, done6, kv6, busy8, done8, kv8;
   logic [0:128*11-1] rk4;
   logic [0:128*13-1] rk6;
   logic [0:128*15-1] rk8;
   int checks = 0;
   int failures = 0;

   localparam logic [255:0] K1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K2 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] K3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [255:0] K4 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};

   aes_key_expand_seq #(.Nk(4)) dut4 (.clk(clk), .reset(reset), .start(start4), .key(key4),
      .busy(busy4), .done(done4), .keys_valid(kv4), .round_keys(rk4));
   aes_key_expand_seq #(.Nk(6)) dut6 (.clk(clk), .reset(reset), .start(start6), .key(key6),
      .busy(busy6), .done(done6), .keys_valid(kv6), .round_keys(rk6));
   aes_key_expand_seq #(.Nk(8)) dut8 (.clk(clk), .reset(reset), .start(start8), .key(key8),
      .busy(busy8), .done(done8), .keys_valid(kv8), .round_keys(rk8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input int nk, input logic [255:0] k, input logic s);
      case (nk)
         4:       begin key4 = k[255:128]; start4 = s; end
         6:       begin key6 = k[255:64];  start6 = s; end
         default: begin key8 = k;          start8 = s; end
      endcase
   endtask

   function automatic logic busy_of(input int nk);
      return (nk == 4) ? busy4 : (nk == 6) ? busy6 : busy8;
   endfunction
   function automatic logic done_of(input int nk);
      return (nk == 4) ? done4 : (nk == 6) ? done6 : done8;
   endfunction
   function automatic logic kv_of(input int nk);
      return (nk == 4) ? kv4 : (nk == 6) ? kv6 : kv8;
   endfunction
   function automatic logic [127:0] rk(input int nk, input int r);
      return (nk == 4) ? rk4[128*r +: 128] : (nk == 6) ? rk6[128*r +: 128] : rk8[128*r +: 128];
   endfunction

   // Stimulus only: accept edge counts as edge 1; an optional start pulse with
   // late_k is raised late_at edges in. Returns edges until done, busy cycles,
   // number of done samples, and keys_valid right after the accept edge.
   task automatic run_expand(input int nk, input logic [255:0] k, input int late_at,
                             input logic [255:0] late_k, output int edges, output int nbusy,
                             output int ndone, output logic kv_acc);
      @(negedge clk);
      drive(nk, k, 1'b1);
      @(negedge clk);
      drive(nk, k, 1'b0);
      edges = 1;
      nbusy = busy_of(nk) ? 1 : 0;
      kv_acc = kv_of(nk);
      ndone = 0;
      while (!done_of(nk) && edges < 200) begin
         if (late_at != 0 && edges == late_at) drive(nk, late_k, 1'b1);
         else if (late_at != 0 && edges == late_at + 1) drive(nk, late_k, 1'b0);
         @(negedge clk);
         edges++;
         if (busy_of(nk)) nbusy++;
      end
      for (int c = 0; c < 5; c++) begin
         if (done_of(nk)) ndone++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(4, '0, 1'b0); drive(6, '0, 1'b0); drive(8, '0, 1'b0);
      repeat (2) @(negedge clk);
      checks++; if ({busy4, done4, kv4} !== 3'b000) begin failures++; $display("FAIL reset_flags4 got %b expected 000", {busy4, done4, kv4}); end
      checks++; if (rk4 !== '0) begin failures++; $display("FAIL reset_rk4 got nonzero expected zero"); end
      checks++; if ({busy8, done8, kv8} !== 3'b000 || rk8 !== '0) begin failures++; $display("FAIL reset_dut8 got flags %b expected 000 and zero keys", {busy8, done8, kv8}); end
      reset = 1'b0;
      @(negedge clk);
      checks++; if ({busy4, done4, kv4} !== 3'b000) begin failures++; $display("FAIL idle_after_reset got %b expected 000", {busy4, done4, kv4}); end
   endtask

   task automatic test_nk4();
      int e, b, d; logic kv;
      run_expand(4, K1, 0, '0, e, b, d, kv);
      checks++; if (e !== 41) begin failures++; $display("FAIL nk4_latency got %0d expected 41", e); end
      checks++; if (b !== 40) begin failures++; $display("FAIL nk4_busy_cycles got %0d expected 40", b); end
      checks++; if (d !== 1) begin failures++; $display("FAIL nk4_done_pulses got %0d expected 1", d); end
      checks++; if ({kv4, busy4} !== 2'b10) begin failures++; $display("FAIL nk4_ready got kv,busy=%b expected 10", {kv4, busy4}); end
      checks++; if (rk4[0 +: 128] !== K1[255:128]) begin failures++; $display("FAIL nk4_round0 got %h expected %h", rk4[0 +: 128], K1[255:128]); end
      checks++; if (rk4[128 +: 32] !== 32'ha0fafe17) begin failures++; $display("FAIL nk4_w4 got %h expected a0fafe17", rk4[128 +: 32]); end
      checks++; if (rk(4, 1) !== 128'ha0fafe1788542cb123a339392a6c7605) begin failures++; $display("FAIL nk4_round1 got %h expected a0fafe1788542cb123a339392a6c7605", rk(4, 1)); end
      checks++; if (rk(4, 10) !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin failures++; $display("FAIL nk4_round10 got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", rk(4, 10)); end
   endtask

   task automatic test_nk6();
      int e, b, d; logic kv;
      run_expand(6, K2, 0, '0, e, b, d, kv);
      checks++; if (e !== 47) begin failures++; $display("FAIL nk6_latency got %0d expected 47", e); end
      checks++; if (d !== 1 || kv6 !== 1'b1) begin failures++; $display("FAIL nk6_done_kv got done=%0d kv=%b expected 1 1", d, kv6); end
      checks++; if (rk(6, 12) !== 128'he98ba06f448c773c8ecc720401002202) begin failures++; $display("FAIL nk6_round12 got %h expected e98ba06f448c773c8ecc720401002202", rk(6, 12)); end
   endtask

   task automatic test_nk8();
      int e, b, d; logic kv;
      run_expand(8, K3, 0, '0, e, b, d, kv);
      checks++; if (e !== 53) begin failures++; $display("FAIL nk8_latency got %0d expected 53", e); end
      checks++; if (b !== 52 || d !== 1) begin failures++; $display("FAIL nk8_busy_done got busy=%0d done=%0d expected 52 1", b, d); end
      checks++; if (rk(8, 14) !== 128'hfe4890d1e6188d0b046df344706c631e) begin failures++; $display("FAIL nk8_round14 got %h expected fe4890d1e6188d0b046df344706c631e", rk(8, 14)); end
   endtask

   task automatic test_ignore_start();
      int e, b, d; logic kv;
      run_expand(4, K1, 10, K4, e, b, d, kv);
      checks++; if (e !== 41 || b !== 40) begin failures++; $display("FAIL ignore_latency got edges=%0d busy=%0d expected 41 40", e, b); end
      checks++; if (d !== 1) begin failures++; $display("FAIL ignore_done_pulses got %0d expected 1", d); end
      checks++; if (rk(4, 10) !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin failures++; $display("FAIL ignore_round10 got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", rk(4, 10)); end
   endtask

   task automatic test_async_reset();
      int e, b, d; logic kv;
      @(negedge clk);
      drive(4, K4, 1'b1);
      @(negedge clk);
      drive(4, K4, 1'b0);
      repeat (19) @(negedge clk);
      checks++; if (busy4 !== 1'b1) begin failures++; $display("FAIL pre_reset_busy got %b expected 1", busy4); end
      #2 reset = 1'b1;
      #1;
      checks++; if ({busy4, kv4, done4} !== 3'b000) begin failures++; $display("FAIL async_reset_flags got %b expected 000", {busy4, kv4, done4}); end
      checks++; if (rk4 !== '0) begin failures++; $display("FAIL async_reset_rk got %h expected zero", rk4[0 +: 128]); end
      @(negedge clk);
      reset = 1'b0;
      run_expand(4, K1, 0, '0, e, b, d, kv);
      checks++; if (e !== 41) begin failures++; $display("FAIL post_reset_latency got %0d expected 41", e); end
      checks++; if (rk4[128 +: 32] !== 32'ha0fafe17) begin failures++; $display("FAIL post_reset_w4 got %h expected a0fafe17", rk4[128 +: 32]); end
   endtask

   task automatic test_restart_ready();
      int e, b, d; logic kv;
      checks++; if (kv4 !== 1'b1) begin failures++; $display("FAIL restart_pre_kv got %b expected 1", kv4); end
      run_expand(4, K4, 0, '0, e, b, d, kv);
      checks++; if (kv !== 1'b0) begin failures++; $display("FAIL restart_kv_drop got %b expected 0", kv); end
      checks++; if (e !== 41 || d !== 1) begin failures++; $display("FAIL restart_timing got edges=%0d done=%0d expected 41 1", e, d); end
      checks++; if (rk(4, 1) !== 128'hd6aa74fdd2af72fadaa678f1d6ab76fe) begin failures++; $display("FAIL restart_round1 got %h expected d6aa74fdd2af72fadaa678f1d6ab76fe", rk(4, 1)); end
      checks++; if (rk(4, 10) !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin failures++; $display("FAIL restart_round10 got %h expected 13111d7fe3944a17f307a78b4d2b30c5", rk(4, 10)); end
   endtask

   initial begin
      test_reset();
      test_nk4();
      test_nk6();
      test_nk8();
      test_ignore_start();
      test_async_reset();
      test_nk4();
      test_restart_ready();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/aes_key_expand_seq.md
Name: aes_key_expand_seq

Overview:
- Sequential AES key schedule (FIPS-197 KeyExpansion). Sits directly upstream of the inverse cipher and forward cipher.
- Accepts one cipher key on a start handshake and computes one 32-bit schedule word per clock.
- Presents the full (Nr+1)x128-bit round-key bus in the layout the cipher datapaths consume, then holds it stable until the next accepted start.

Parameters:
- Nk, 4, key length in 32-bit words; legal values are 4, 6 and 8 (AES-128/192/256). Any other value is an elaboration error.
- Nr, Nk+6, number of rounds. Derived; do not override independently.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to expand key; sampled on rising clk.
- key  input  32*Nk  cipher key, [0:32*Nk-1]; bits [0:31] = w[0] (FIPS byte order, MSB first).
- busy  output  1  high while expansion is in progress.
- done  output  1  single-cycle pulse when round_keys becomes valid.
- keys_valid  output  1  level; high while round_keys holds a complete schedule.
- round_keys  output  128*(Nr+1)  [0:128*(Nr+1)-1]; word w[n] occupies bits [32n : 32n+31]. Round r key = bits [128r +: 128].

Behaviour:
- Reset (async, any time including mid-expansion):
  - state=IDLE.
  - busy, done, keys_valid = 0.
  - All round_keys bits = 0; word counter and Rcon register cleared.
- States:
  - IDLE: outputs idle.
  - EXPAND: busy=1.
  - READY: keys_valid=1.
- Transitions:
  - IDLE/READY with start=1 -> EXPAND. On that edge:
    - key is latched into w[0..Nk-1].
    - keys_valid clears.
    - i=Nk, j=0 (j = i mod Nk), rcon=0x01.
  - EXPAND -> READY on the edge that writes w[4*(Nr+1)-1]. On that edge keys_valid is set and done is high for the following cycle only.
  - start while in EXPAND is ignored; no restart and no queueing.
  - start in READY restarts the expansion and discards the old schedule (keys_valid falls on the accept edge).
- Per-cycle word computation in EXPAND:
  - temp = w[i-1].
  - If j==0: temp = SubWord(RotWord(temp)) XOR {rcon,24'h0}, then rcon <= xtime(rcon) (x<<1, XOR 0x1B if MSB set).
  - Else if Nk==8 and j==4: temp = SubWord(temp).
  - w[i] <= w[i-Nk] XOR temp; i <= i+1; j <= (j==Nk-1) ? 0 : j+1.
- RotWord: cyclic left by one byte. SubWord: AES forward S-box on each byte via an internal 256-entry table. One S-box word lookup path only (4 byte lookups per cycle).
- Latency, accept edge to keys_valid=1:
  - Nk=4: 41 rising edges.
  - Nk=6: 47 rising edges.
  - Nk=8: 53 rising edges.
  - Formula: 1 + 4*(Nr+1) - Nk.
- round_keys words not yet written during EXPAND hold stale/zero content. Consumers use only keys_valid.
- Counter i width: 6 bits (max 59). No wrap occurs; expansion stops at the last word.

Test Plan:
- Reset then Nk=4, start with key 2b7e151628aed2a6abf7158809cf4f3c -> w[4]=a0fafe17 and w[43]=b6630ca6. Round 10 key = d014f9a8c9ee2589e13f0cc8b6630ca6. done pulses exactly 41 edges after the accept edge; busy high for 40 cycles.
- Nk=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> w[48..51]=e98ba06f 448c773c 8ecc7204 01002202; latency 47.
- Nk=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> w[56..59]=fe4890d1 e6188d0b 046df344 706c631e; latency 53; exercises the j==4 SubWord path.
- Nk=4: pulse start again 10 cycles into EXPAND with a different key -> ignored; result still matches the first key and latency is unchanged.
- Assert reset asynchronously at cycle 20 of an expansion -> busy, keys_valid and round_keys = 0 immediately. A new start then completes correctly with Rcon restarting at 01 (w[4] matches the first scenario).
- From READY, start with key 000102030405060708090a0b0c0d0e0f -> keys_valid drops on the accept edge. The last round key becomes 13111d7fe3944a17f307a78b4d2b30c5, with a single done pulse.
